// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO collector: default data width and batch
// depth, plus the collector state encoding.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collector_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_collector.sv
// -----------------------------------------------------------------------------
// fifo_collector
// Drains DEPTH words from an upstream shift FIFO into a local register array,
// then holds the batch for random-access readback over an MMIO-style port.
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset (clears state, outputs and storage)
//   in_valid  upstream presents a word on in_data
//   in_data   upstream word (WIDTH bits, stored bit-exact)
//   in_ready  collector accepts in_data this cycle (high while collecting)
//   clr       discard the batch and restart collection (storage kept)
//   rd_en     read request
//   rd_addr   index of word to read
//   rd_data   registered read result (holds when no read)
//   rd_valid  rd_data carries the result of last cycle's rd_en
//   count     words captured in the current batch
//   full      batch complete (count == DEPTH)
// -----------------------------------------------------------------------------
module fifo_collector
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       clr,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  collector_state_t       state, state_next;
  logic [CW-1:0]          count_next;
  logic                   wr_en;
  logic [WIDTH-1:0]       mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this from inferring latches.
  always_comb begin
    state_next = state;
    count_next = count;
    wr_en      = 1'b0;

    if (clr) begin
      // clr outranks an accepted word: the word is dropped, not stored.
      state_next = COLLECT;
      count_next = '0;
    end else if (state == COLLECT && in_valid) begin
      wr_en      = 1'b1;
      count_next = count + CW'(1);
      if (count == LAST_IDX) begin
        state_next = HOLD;
      end
    end
  end

  assign in_ready = (state == COLLECT);
  assign full     = (count == FULL_CNT);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately reset to zero, so it stays flops rather
  // than mapping to RAM; unwritten indices must read back 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[count[AW-1:0]] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port. Sampling mem on the same edge as a write yields the
  // old word, giving read-before-write for a same-index collision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule : fifo_collector

// File: tb/tb_fifo_collector.sv
// -----------------------------------------------------------------------------
// tb_fifo_collector
// Directed bench for fifo_collector with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_fifo_collector;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             clr;
  logic             rd_en;
  logic [2:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [3:0]       count;
  logic             full;

  int tests  = 0;
  int failed = 0;

  logic [63:0] vals [8];

  fifo_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr      (clr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic read(input int a, input logic [63:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = 3'(a);
    step();
    rd_en   = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    vals[0] = 64'sd1;
    vals[1] = -64'sd8;
    vals[2] = 64'sd3;
    vals[3] = 64'sd16457;
    vals[4] = 64'sd89320567;
    vals[5] = 64'sd58947128924718;
    vals[6] = -64'sd123567;
    vals[7] = 64'sd55;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clr      = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;

    // Reset state
    #12;
    check("rst_count",    64'(count),    64'd0);
    check("rst_full",     64'(full),     64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data",  rd_data,       64'd0);
    rst_n = 1'b1;
    step();

    // Fill a full batch on consecutive cycles
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = vals[i];
      step();
      check($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
    end
    in_valid = 1'b0;
    check("fill_full",     64'(full),     64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);

    // Back-to-back readback in HOLD
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      step();
      check($sformatf("b2b_valid%0d", i), 64'(rd_valid), 64'd1);
      check($sformatf("b2b_data%0d", i),  rd_data,       vals[i]);
    end
    rd_en = 1'b0;
    step();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_rd_hold",  rd_data,       vals[7]);

    // HOLD ignores in_valid
    push(64'd800);
    check("hold_count", 64'(count), 64'd8);
    check("hold_full",  64'(full),  64'd1);
    read(7, 64'd55, "hold_rd7");
    read(0, 64'd1,  "hold_rd0");

    // clr from HOLD restarts collection
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_count",    64'(count),    64'd0);
    check("clr_full",     64'(full),     64'd0);
    check("clr_in_ready", 64'(in_ready), 64'd1);

    // New partial batch overwrites indices 0..3
    push(64'd10);
    push(64'd20);
    push(64'd30);
    push(64'd40);
    check("b2_count4", 64'(count), 64'd4);

    // clr with an accepted word and a read: word dropped, read sees old data
    in_valid = 1'b1;
    in_data  = 64'sd89320567;
    clr      = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 3'd0;
    step();
    in_valid = 1'b0;
    clr      = 1'b0;
    rd_en    = 1'b0;
    check("clrwr_count",    64'(count),    64'd0);
    check("clrwr_rd_valid", 64'(rd_valid), 64'd1);
    check("clrwr_rd_data",  rd_data,       64'd10);

    // Next word lands at index 0
    push(64'd77);
    check("after_clr_count", 64'(count), 64'd1);
    read(0, 64'd77, "after_clr_rd0");
    read(5, vals[5], "stale_rd5");

    // Read-before-write on the same index
    in_valid = 1'b1;
    in_data  = 64'd99;
    rd_en    = 1'b1;
    rd_addr  = 3'd1;
    step();
    in_valid = 1'b0;
    rd_en    = 1'b0;
    check("rbw_old",   rd_data,       64'd20);
    check("rbw_count", 64'(count),    64'd2);
    read(1, 64'd99, "rbw_new");

    // Reset mid-batch, during a read
    push(64'd111);
    push(64'd222);
    push(64'd333);
    check("pre_rst_count", 64'(count), 64'd5);
    rd_en   = 1'b1;
    rd_addr = 3'd2;
    step();
    check("pre_rst_rd", rd_data, 64'd111);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",    64'(count),    64'd0);
    check("arst_full",     64'(full),     64'd0);
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_rd_data",  rd_data,       64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    rd_en = 1'b0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      read(i, 64'd0, $sformatf("post_rst_rd%0d", i));
    end

    push(64'hFFFF_FFFF_FFFF_FFFE);
    check("post_rst_count", 64'(count), 64'd1);
    read(0, 64'hFFFF_FFFF_FFFF_FFFE, "post_rst_word0");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_fifo_collector

// File: doc/fifo_collector.md
FIFO_COLLECTOR -- requirements
Module: fifo_collector

Interface
REQ-001 Parameter WIDTH, default 64, data word width in bits, signed two's complement.
REQ-002 Parameter DEPTH, default 8, number of words captured per batch; a power of two, minimum 2.
REQ-003 Port clk, input, 1 bit, sole clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit, the upstream shift FIFO is presenting a word on in_data.
REQ-006 Port in_data, input, WIDTH bits, the word from the FIFO output.
REQ-007 Port in_ready, output, 1 bit, the collector accepts in_data this cycle.
REQ-008 Port clr, input, 1 bit, discard the batch and restart collection.
REQ-009 Port rd_en, input, 1 bit, MMIO-side read request.
REQ-010 Port rd_addr, input, log2(DEPTH) bits, index of the word to read.
REQ-011 Port rd_data, output, WIDTH bits, read result, registered.
REQ-012 Port rd_valid, output, 1 bit, rd_data holds the result of the previous cycle's rd_en.
REQ-013 Port count, output, log2(DEPTH)+1 bits, number of words captured in the current batch.
REQ-014 Port full, output, 1 bit, the batch is complete (count == DEPTH).

Function
REQ-015 The state machine SHALL have two states: COLLECT and HOLD.
REQ-016 In COLLECT, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-017 A word is accepted on any edge where in_valid && in_ready; it SHALL be stored at index count, and count SHALL increment by 1.
REQ-018 When the accepted word is number DEPTH, the state SHALL become HOLD and full SHALL be 1 from the next cycle onward.
REQ-019 In HOLD, in_valid SHALL be ignored; storage and count SHALL remain unchanged.
REQ-020 rd_en at cycle N SHALL produce rd_data = storage[rd_addr] and rd_valid = 1 at cycle N+1; one-cycle latency; back-to-back reads are allowed every cycle.
REQ-021 Without rd_en, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-022 Reads are legal in both states; reading an index >= count returns the stale word stored there, or 0 if that index was never written since reset.
REQ-023 clr SHALL set count to 0, set the state to COLLECT, and leave storage contents intact.
REQ-024 clr together with an accepted in_valid: clr wins and the word is dropped.
REQ-025 clr together with rd_en: the read completes normally with pre-clear data.
REQ-026 A read and a write to the same index in the same cycle SHALL return the old word (read-before-write).
REQ-027 No arithmetic is performed on data; words are stored bit-exact, sign preserved.

Reset
REQ-028 Asserting rst_n low SHALL, asynchronously, set state=COLLECT, count=0, full=0, rd_valid=0, rd_data=0, and all storage words to 0.
REQ-029 Reset asserted mid-batch or mid-read SHALL abort the batch; the first edge after release behaves as COLLECT with count 0.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the WIDTH and DEPTH defaults and the collector state enum (COLLECT, HOLD).
REQ-031 No sub-module is needed: storage is an in-module register array indexed by the count and rd_addr pointers.

Verification
REQ-032 Reset, then present 1, -8, 3, 16457, 89320567, 58947128924718, -123567, 55 on consecutive cycles -> count reaches 8, full=1, in_ready=0.
REQ-033 In HOLD, read addresses 0..7 back-to-back -> rd_valid=1 each following cycle, returning the eight values in order, with signed values exact.
REQ-034 In HOLD, drive in_valid=1 with in_data=800 -> storage unchanged; reading address 7 returns 55.
REQ-035 Pulse clr while accepting word 4 (value 89320567) mid-batch -> count=0, the word is dropped, and the next accepted word lands at index 0.
REQ-036 Assert rst_n low after 5 words, during an rd_en -> all outputs read 0 immediately, and every address reads back 0.
